alu_operand_stage: RTL and testbench

- ID/EX pipeline stage directly upstream of the ALU.
- Registers one decoded instruction under a valid/ready handshake and selects operands (rs1/PC, rs2/imm).
- Resolves data hazards by forwarding from EX/MEM and MEM/WB, holding on load-use, and flushing on branch redirect.
- Drives the ALU's SrcA, SrcB and Operation inputs plus EX-stage sideband.

---
 rtl/alu_operand_stage_pkg.sv | 44 ++++
 rtl/alu_operand_stage_if.sv | 69 ++++++
 rtl/alu_operand_stage_fwd_mux.sv | 47 ++++
 rtl/alu_operand_stage.sv | 137 +++++++++++++
 tb/tb_alu_operand_stage.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU operation codes and operand-stage enumerations.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation codes as consumed by the downstream ALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_BEQ = 4'b1000;
    localparam logic [3:0] ALU_BNE = 4'b1001;
    localparam logic [3:0] ALU_BGE = 4'b1011;
    localparam logic [3:0] ALU_SLT = 4'b1100;
    localparam logic [3:0] ALU_JAL = 4'b1101;
    localparam logic [3:0] ALU_BLT = 4'b1110;
    // NOP makes the ALU produce 0; driven whenever nothing is held.
    localparam logic [3:0] ALU_NOP = 4'b1111;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        FULL      = 2'd1,
        WAIT_LOAD = 2'd2
    } stage_state_t;

    typedef enum logic {
        SRC_A_RS1 = 1'b0,
        SRC_A_PC  = 1'b1
    } src_a_sel_t;

    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } src_b_sel_t;

endpackage
`default_nettype wire

// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : ID-side handshake, bypass buses and EX-side outputs of the
//                ALU operand stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    // ID side
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     id_pc;
    logic [DATA_WIDTH-1:0]     id_rs1_data;
    logic [DATA_WIDTH-1:0]     id_rs2_data;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
    logic [OPCODE_LENGTH-1:0]  id_alu_op;
    logic                      id_src_a_sel;
    logic                      id_src_b_sel;
    logic                      id_reg_write;
    logic                      flush;
    // Bypass sources
    logic [REG_ADDR_WIDTH-1:0] exm_rd_addr;
    logic                      exm_reg_write;
    logic                      exm_is_load;
    logic [DATA_WIDTH-1:0]     exm_result;
    logic [REG_ADDR_WIDTH-1:0] mwb_rd_addr;
    logic                      mwb_reg_write;
    logic [DATA_WIDTH-1:0]     mwb_result;
    // EX side
    logic                      out_ready;
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [OPCODE_LENGTH-1:0]  Operation;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
    logic                      ex_reg_write;
    logic [DATA_WIDTH-1:0]     ex_pc;

    // Environment side: decode, later pipeline stages and the ALU.
    modport master (
        output in_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
               id_src_a_sel, id_src_b_sel, id_reg_write, flush,
               exm_rd_addr, exm_reg_write, exm_is_load, exm_result,
               mwb_rd_addr, mwb_reg_write, mwb_result, out_ready,
        input  in_ready, ex_valid, SrcA, SrcB, Operation, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_pc
    );

    // The operand stage itself.
    modport slave (
        input  in_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op,
               id_src_a_sel, id_src_b_sel, id_reg_write, flush,
               exm_rd_addr, exm_reg_write, exm_is_load, exm_result,
               mwb_rd_addr, mwb_reg_write, mwb_result, out_ready,
        output in_ready, ex_valid, SrcA, SrcB, Operation, ex_store_data,
               ex_rd_addr, ex_reg_write, ex_pc
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_mux
//  Description : Per-source bypass: compares one source index against the
//                EX/MEM and MEM/WB destinations and selects the newest value.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic [REG_ADDR_WIDTH-1:0] i_src_addr,
    input  wire logic [DATA_WIDTH-1:0]     i_held_data,
    input  wire logic [REG_ADDR_WIDTH-1:0] i_exm_rd_addr,
    input  wire logic                      i_exm_reg_write,
    input  wire logic                      i_exm_is_load,
    input  wire logic [DATA_WIDTH-1:0]     i_exm_result,
    input  wire logic [REG_ADDR_WIDTH-1:0] i_mwb_rd_addr,
    input  wire logic                      i_mwb_reg_write,
    input  wire logic [DATA_WIDTH-1:0]     i_mwb_result,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_load_hit,
    output logic                           o_mwb_hit
);
    // x0 is hard-wired zero and never takes a bypass.
    logic w_src_nonzero;
    logic w_exm_match;
    logic w_exm_fwd;

    assign w_src_nonzero = (i_src_addr != '0);
    assign w_exm_match   = w_src_nonzero && i_exm_reg_write && (i_exm_rd_addr == i_src_addr);
    // A load in EX/MEM has no data yet: flag it as a hazard instead of forwarding.
    assign o_load_hit    = w_exm_match && i_exm_is_load;
    assign w_exm_fwd     = w_exm_match && !i_exm_is_load;
    assign o_mwb_hit     = w_src_nonzero && i_mwb_reg_write && (i_mwb_rd_addr == i_src_addr);

    // Youngest producer wins: EX/MEM, then MEM/WB, then the held register value.
    always_comb begin
        o_data = i_held_data;
        if (w_exm_fwd) begin
            o_data = i_exm_result;
        end else if (o_mwb_hit) begin
            o_data = i_mwb_result;
        end
    end
endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : ID/EX register ahead of the ALU with operand selection,
//                EX/MEM + MEM/WB forwarding, load-use hold and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_operand_stage_if.slave bus
);
    localparam logic [OPCODE_LENGTH-1:0] C_OP_NOP = OPCODE_LENGTH'(ALU_NOP);

    stage_state_t              r_state;
    logic [DATA_WIDTH-1:0]     r_pc;
    logic [DATA_WIDTH-1:0]     r_rs1_data;
    logic [DATA_WIDTH-1:0]     r_rs2_data;
    logic [DATA_WIDTH-1:0]     r_imm;
    logic [REG_ADDR_WIDTH-1:0] r_rs1_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rs2_addr;
    logic [REG_ADDR_WIDTH-1:0] r_rd_addr;
    logic [OPCODE_LENGTH-1:0]  r_alu_op;
    src_a_sel_t                r_src_a_sel;
    src_b_sel_t                r_src_b_sel;
    logic                      r_reg_write;

    logic [DATA_WIDTH-1:0]     w_rs1_fwd;
    logic [DATA_WIDTH-1:0]     w_rs2_fwd;
    logic                      w_rs1_load_hit;
    logic                      w_rs2_load_hit;
    logic                      w_rs1_mwb_hit;
    logic                      w_rs2_mwb_hit;
    logic                      w_hazard;
    logic                      w_ex_valid;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_retire;

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
        .i_src_addr      (r_rs1_addr),
        .i_held_data     (r_rs1_data),
        .i_exm_rd_addr   (bus.exm_rd_addr),
        .i_exm_reg_write (bus.exm_reg_write),
        .i_exm_is_load   (bus.exm_is_load),
        .i_exm_result    (bus.exm_result),
        .i_mwb_rd_addr   (bus.mwb_rd_addr),
        .i_mwb_reg_write (bus.mwb_reg_write),
        .i_mwb_result    (bus.mwb_result),
        .o_data          (w_rs1_fwd),
        .o_load_hit      (w_rs1_load_hit),
        .o_mwb_hit       (w_rs1_mwb_hit)
    );

    fwd_mux #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
        .i_src_addr      (r_rs2_addr),
        .i_held_data     (r_rs2_data),
        .i_exm_rd_addr   (bus.exm_rd_addr),
        .i_exm_reg_write (bus.exm_reg_write),
        .i_exm_is_load   (bus.exm_is_load),
        .i_exm_result    (bus.exm_result),
        .i_mwb_rd_addr   (bus.mwb_rd_addr),
        .i_mwb_reg_write (bus.mwb_reg_write),
        .i_mwb_result    (bus.mwb_result),
        .o_data          (w_rs2_fwd),
        .o_load_hit      (w_rs2_load_hit),
        .o_mwb_hit       (w_rs2_mwb_hit)
    );

    // rs1 matters only when it feeds SrcA; rs2 always matters since it is also store data.
    assign w_hazard   = (w_rs1_load_hit && (r_src_a_sel == SRC_A_RS1)) || w_rs2_load_hit;
    assign w_ex_valid = (r_state == FULL) && !w_hazard;
    assign w_in_ready = (r_state == EMPTY) || (w_ex_valid && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_retire   = w_ex_valid && bus.out_ready;

    assign bus.in_ready      = w_in_ready;
    assign bus.ex_valid      = w_ex_valid;
    assign bus.SrcA          = (r_src_a_sel == SRC_A_PC)  ? r_pc  : w_rs1_fwd;
    assign bus.SrcB          = (r_src_b_sel == SRC_B_IMM) ? r_imm : w_rs2_fwd;
    assign bus.ex_store_data = w_rs2_fwd;
    assign bus.Operation     = (r_state == EMPTY) ? C_OP_NOP : r_alu_op;
    assign bus.ex_rd_addr    = r_rd_addr;
    assign bus.ex_reg_write  = r_reg_write && w_ex_valid;
    assign bus.ex_pc         = r_pc;

    // Stage state and held instruction: flush > accept > retire > hold (with refresh).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= EMPTY;
            r_pc        <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rd_addr   <= '0;
            r_alu_op    <= '0;
            r_src_a_sel <= SRC_A_RS1;
            r_src_b_sel <= SRC_B_RS2;
            r_reg_write <= 1'b0;
        end else if (bus.flush) begin
            r_state <= EMPTY;
        end else if (w_accept) begin
            r_state     <= FULL;
            r_pc        <= bus.id_pc;
            r_rs1_data  <= bus.id_rs1_data;
            r_rs2_data  <= bus.id_rs2_data;
            r_imm       <= bus.id_imm;
            r_rs1_addr  <= bus.id_rs1_addr;
            r_rs2_addr  <= bus.id_rs2_addr;
            r_rd_addr   <= bus.id_rd_addr;
            r_alu_op    <= bus.id_alu_op;
            r_src_a_sel <= src_a_sel_t'(bus.id_src_a_sel);
            r_src_b_sel <= src_b_sel_t'(bus.id_src_b_sel);
            r_reg_write <= bus.id_reg_write;
        end else if (w_retire) begin
            r_state <= EMPTY;
        end else if (r_state != EMPTY) begin
            // Capture write-backs while waiting so a value leaving MEM/WB is not lost.
            if (w_rs1_mwb_hit) begin
                r_rs1_data <= bus.mwb_result;
            end
            if (w_rs2_mwb_hit) begin
                r_rs2_data <= bus.mwb_result;
            end
            r_state <= w_hazard ? WAIT_LOAD : FULL;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;
    import alu_pkg::*;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int AW = 5;

    typedef struct packed {
        logic [DW-1:0] srca;
        logic [DW-1:0] srcb;
        logic [DW-1:0] store;
        logic [OW-1:0] op;
        logic [AW-1:0] rd;
        logic          rw;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   sb_on  = 1'b0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    alu_operand_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) bus();

    alu_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Scoreboard: every retirement (ex_valid && out_ready) consumes the oldest expectation.
    always @(negedge clk) begin
        if (sb_on && bus.ex_valid && bus.out_ready) begin
            exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: retired SrcA=%h with no expected entry", bus.SrcA);
            end else begin
                e = sb_q.pop_front();
                if ({bus.SrcA, bus.SrcB, bus.ex_store_data, bus.Operation, bus.ex_rd_addr, bus.ex_reg_write} !== e) begin
                    errors++;
                    $display("FAIL sb_retire: got SrcA=%h SrcB=%h st=%h op=%h rd=%0d rw=%b expected SrcA=%h SrcB=%h st=%h op=%h rd=%0d rw=%b",
                             bus.SrcA, bus.SrcB, bus.ex_store_data, bus.Operation, bus.ex_rd_addr, bus.ex_reg_write,
                             e.srca, e.srcb, e.store, e.op, e.rd, e.rw);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid      = 1'b0;
        bus.id_pc         = '0;
        bus.id_rs1_data   = '0;
        bus.id_rs2_data   = '0;
        bus.id_imm        = '0;
        bus.id_rs1_addr   = '0;
        bus.id_rs2_addr   = '0;
        bus.id_rd_addr    = '0;
        bus.id_alu_op     = '0;
        bus.id_src_a_sel  = 1'b0;
        bus.id_src_b_sel  = 1'b0;
        bus.id_reg_write  = 1'b0;
        bus.flush         = 1'b0;
        bus.exm_rd_addr   = '0;
        bus.exm_reg_write = 1'b0;
        bus.exm_is_load   = 1'b0;
        bus.exm_result    = '0;
        bus.mwb_rd_addr   = '0;
        bus.mwb_reg_write = 1'b0;
        bus.mwb_result    = '0;
        bus.out_ready     = 1'b1;
    endtask

    task automatic drive_instr(input logic [DW-1:0] pc, input logic [DW-1:0] rs1d,
                               input logic [DW-1:0] rs2d, input logic [DW-1:0] imm,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic [AW-1:0] rd, input logic [OW-1:0] op,
                               input logic asel, input logic bsel, input logic rw);
        bus.in_valid     = 1'b1;
        bus.id_pc        = pc;
        bus.id_rs1_data  = rs1d;
        bus.id_rs2_data  = rs2d;
        bus.id_imm       = imm;
        bus.id_rs1_addr  = rs1;
        bus.id_rs2_addr  = rs2;
        bus.id_rd_addr   = rd;
        bus.id_alu_op    = op;
        bus.id_src_a_sel = asel;
        bus.id_src_b_sel = bsel;
        bus.id_reg_write = rw;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.Operation !== ALU_NOP) begin
            errors++;
            $display("FAIL reset_hold: ex_valid=%b op=%h expected 0 and f", bus.ex_valid, bus.Operation);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if ({bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_pc} !== '0 || bus.ex_rd_addr !== '0 || bus.ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: SrcA=%h SrcB=%h st=%h pc=%h rd=%0d rw=%b expected all 0",
                     bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_pc, bus.ex_rd_addr, bus.ex_reg_write);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        sb_q.delete();
        sb_on = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_instr(32'h1000 + 4*i, 32'd7 + i, 32'd0, 32'd3 + i, 5'd5, 5'd0, AW'(i + 1), ALU_ADD, 1'b0, 1'b1, 1'b1);
            sb_q.push_back('{srca: 32'd7 + i, srcb: 32'd3 + i, store: 32'd0, op: ALU_ADD, rd: AW'(i + 1), rw: 1'b1});
            settle();
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            if (i > 0) begin
                checks++;
                if (bus.ex_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_no_bubble[%0d]: ex_valid=%b expected 1", i, bus.ex_valid);
                end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d entries left expected 0", sb_q.size());
        end
        sb_on = 1'b0;
    endtask

    task automatic test_forward_priority();
        idle_inputs();
        bus.out_ready = 1'b0;
        drive_instr(32'h200, 32'h1, 32'h0, 32'h5, 5'd4, 5'd0, 5'd8, ALU_ADD, 1'b0, 1'b1, 1'b1);
        tick();
        bus.in_valid      = 1'b0;
        bus.exm_rd_addr   = 5'd4;
        bus.exm_reg_write = 1'b1;
        bus.exm_result    = 32'h22;
        bus.mwb_rd_addr   = 5'd4;
        bus.mwb_reg_write = 1'b1;
        bus.mwb_result    = 32'h33;
        settle();
        checks++;
        if (bus.SrcA !== 32'h22) begin
            errors++;
            $display("FAIL fwd_exm_first: SrcA=%h expected 22", bus.SrcA);
        end
        bus.exm_reg_write = 1'b0;
        settle();
        checks++;
        if (bus.SrcA !== 32'h33) begin
            errors++;
            $display("FAIL fwd_mwb: SrcA=%h expected 33", bus.SrcA);
        end
        bus.mwb_reg_write = 1'b0;
        settle();
        checks++;
        if (bus.SrcA !== 32'h1 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL fwd_held: SrcA=%h ex_valid=%b expected 1 and 1", bus.SrcA, bus.ex_valid);
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive_instr(32'h300, 32'h0, 32'h5, 32'h66, 5'd0, 5'd9, 5'd10, ALU_ADD, 1'b0, 1'b1, 1'b1);
        tick();
        bus.in_valid      = 1'b0;
        bus.exm_rd_addr   = 5'd0;
        bus.exm_reg_write = 1'b1;
        bus.exm_result    = 32'h99;
        bus.mwb_rd_addr   = 5'd9;
        bus.mwb_reg_write = 1'b1;
        bus.mwb_result    = 32'h44;
        settle();
        checks++;
        if (bus.SrcA !== 32'h0) begin
            errors++;
            $display("FAIL fwd_x0: SrcA=%h expected 0", bus.SrcA);
        end
        checks++;
        if (bus.ex_store_data !== 32'h44 || bus.SrcB !== 32'h66) begin
            errors++;
            $display("FAIL fwd_store: st=%h SrcB=%h expected 44 and 66", bus.ex_store_data, bus.SrcB);
        end
        idle_inputs();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic test_load_use();
        idle_inputs();
        bus.out_ready = 1'b0;
        drive_instr(32'h400, 32'h10, 32'h55, 32'h0, 5'd1, 5'd6, 5'd7, ALU_SUB, 1'b0, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        settle();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.SrcB !== 32'h55) begin
            errors++;
            $display("FAIL lu_before: ex_valid=%b SrcB=%h expected 1 and 55", bus.ex_valid, bus.SrcB);
        end
        bus.exm_rd_addr   = 5'd6;
        bus.exm_reg_write = 1'b1;
        bus.exm_is_load   = 1'b1;
        bus.exm_result    = 32'hDEAD;
        settle();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL lu_detect: ex_valid=%b in_ready=%b rw=%b expected 0 0 0", bus.ex_valid, bus.in_ready, bus.ex_reg_write);
        end
        checks++;
        if (bus.SrcB !== 32'h55) begin
            errors++;
            $display("FAIL lu_no_load_fwd: SrcB=%h expected 55", bus.SrcB);
        end
        tick();
        bus.exm_reg_write = 1'b0;
        bus.exm_is_load   = 1'b0;
        bus.mwb_rd_addr   = 5'd6;
        bus.mwb_reg_write = 1'b1;
        bus.mwb_result    = 32'hAB;
        settle();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.SrcB !== 32'hAB) begin
            errors++;
            $display("FAIL lu_wait: ex_valid=%b in_ready=%b SrcB=%h expected 0 0 ab", bus.ex_valid, bus.in_ready, bus.SrcB);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.SrcB !== 32'hAB || bus.ex_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL lu_release: ex_valid=%b SrcB=%h rw=%b expected 1 ab 1", bus.ex_valid, bus.SrcB, bus.ex_reg_write);
        end
        bus.mwb_reg_write = 1'b0;
        bus.mwb_rd_addr   = 5'd0;
        settle();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.SrcB !== 32'hAB) begin
            errors++;
            $display("FAIL lu_refresh: ex_valid=%b SrcB=%h expected 1 ab", bus.ex_valid, bus.SrcB);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_retire: ex_valid=%b in_ready=%b expected 0 1", bus.ex_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        sb_q.delete();
        sb_on = 1'b1;
        drive_instr(32'h500, 32'h100, 32'h0, 32'h4, 5'd2, 5'd0, 5'd3, ALU_OR, 1'b0, 1'b1, 1'b1);
        sb_q.push_back('{srca: 32'h100, srcb: 32'h4, store: 32'h0, op: ALU_OR, rd: 5'd3, rw: 1'b1});
        tick();
        bus.out_ready = 1'b0;
        drive_instr(32'h504, 32'h200, 32'h0, 32'h8, 5'd3, 5'd0, 5'd4, ALU_XOR, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.ex_valid !== 1'b1 || bus.SrcA !== 32'h100 || bus.Operation !== ALU_OR) begin
                errors++;
                $display("FAIL bp_stall[%0d]: in_ready=%b ex_valid=%b SrcA=%h op=%h expected 0 1 100 1",
                         i, bus.in_ready, bus.ex_valid, bus.SrcA, bus.Operation);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        sb_q.push_back('{srca: 32'h200, srcb: 32'h8, store: 32'h0, op: ALU_XOR, rd: 5'd4, rw: 1'b1});
        settle();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b expected 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        settle();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.SrcA !== 32'h200) begin
            errors++;
            $display("FAIL bp_swap: ex_valid=%b SrcA=%h expected 1 200", bus.ex_valid, bus.SrcA);
        end
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d entries left expected 0", sb_q.size());
        end
        sb_on = 1'b0;
    endtask

    task automatic test_flush();
        idle_inputs();
        bus.out_ready = 1'b0;
        drive_instr(32'h600, 32'h11, 32'h0, 32'h0, 5'd1, 5'd0, 5'd2, ALU_AND, 1'b0, 1'b1, 1'b1);
        tick();
        drive_instr(32'h604, 32'hCC, 32'h0, 32'h0, 5'd2, 5'd0, 5'd3, ALU_SLL, 1'b0, 1'b1, 1'b1);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        settle();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready);
        end
        tick();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        settle();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.SrcA !== 32'h11 || bus.ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: ex_valid=%b in_ready=%b SrcA=%h rw=%b expected 0 1 11 0",
                     bus.ex_valid, bus.in_ready, bus.SrcA, bus.ex_reg_write);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_stay_empty: ex_valid=%b expected 0", bus.ex_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        idle_inputs();
        bus.out_ready = 1'b0;
        drive_instr(32'h700, 32'h10, 32'h20, 32'h30, 5'd1, 5'd2, 5'd9, ALU_ADD, 1'b0, 1'b0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.SrcA !== 32'h10 || bus.ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: SrcA=%h ex_valid=%b expected 10 1", bus.SrcA, bus.ex_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.Operation !== ALU_NOP || bus.ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ctrl: ex_valid=%b op=%h rw=%b expected 0 f 0", bus.ex_valid, bus.Operation, bus.ex_reg_write);
        end
        checks++;
        if ({bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_pc} !== '0 || bus.ex_rd_addr !== '0) begin
            errors++;
            $display("FAIL rst_mid_data: SrcA=%h SrcB=%h st=%h pc=%h rd=%0d expected all 0",
                     bus.SrcA, bus.SrcB, bus.ex_store_data, bus.ex_pc, bus.ex_rd_addr);
        end
        #3;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: in_ready=%b ex_valid=%b expected 1 0", bus.in_ready, bus.ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_forward_priority();
        test_load_use();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
